// File: rtl/bsg_cgol_pkg.sv
// ---------------------------------------------------------------------------
// bsg_cgol_pkg
// Shared definitions for the CGOL accelerator front end.
//   - deser_state_e    : input deserializer state (header, body, full)
//   - hdr_frames_lsb_gp: bit position of the frame count inside a header word
//   - safe_clog2       : ceil(log2(x)) that never returns 0, so a counter
//                        sized from it always has at least one bit
// ---------------------------------------------------------------------------
package bsg_cgol_pkg;

   // The frame count occupies the low bits of the header word; anything above
   // the frame-count field is ignored.
   localparam int hdr_frames_lsb_gp = 0;

   typedef enum logic [1:0] {
      e_header = 2'd0,
      e_body   = 2'd1,
      e_full   = 2'd2
   } deser_state_e;

   function automatic int safe_clog2(input int x);
      return (x <= 1) ? 1 : $clog2(x);
   endfunction

endpackage

// File: rtl/bsg_cgol_word_assembler.sv
// ---------------------------------------------------------------------------
// bsg_cgol_word_assembler
// Register array holding a board image that is filled one data word at a
// time. Word k lands in board bits [k*data_width_p +: data_width_p]; the
// final word is truncated to whatever board bits remain.
// Ports:
//   clk_i    - clock
//   reset_i  - synchronous active-high clear of the whole board
//   w_v_i    - write enable for the word selected by w_idx_i
//   w_idx_i  - word index, 0..words_lp-1
//   data_i   - word to write
//   board_o  - registered board image
// ---------------------------------------------------------------------------
module bsg_cgol_word_assembler
   import bsg_cgol_pkg::*;
#(
   parameter int data_width_p  = 64,
   parameter int board_bits_lp = 1024,
   localparam int words_lp     = (board_bits_lp + data_width_p - 1) / data_width_p,
   localparam int idx_width_lp = safe_clog2(words_lp)
) (
   input  logic                     clk_i,
   input  logic                     reset_i,
   input  logic                     w_v_i,
   input  logic [idx_width_lp-1:0]  w_idx_i,
   input  logic [data_width_p-1:0]  data_i,
   output logic [board_bits_lp-1:0] board_o
);

   logic [board_bits_lp-1:0] board_r;

   // One register slice per word. The last slice may be narrower than a full
   // word, in which case only the low bits of data_i are kept.
   for (genvar k = 0; k < words_lp; k++) begin : g_word
      localparam int lo_lp = k * data_width_p;
      localparam int hi_lp = ((lo_lp + data_width_p) > board_bits_lp)
                             ? board_bits_lp : (lo_lp + data_width_p);
      localparam int w_lp  = hi_lp - lo_lp;

      always_ff @(posedge clk_i) begin
         if (reset_i) begin
            board_r[hi_lp-1:lo_lp] <= '0;
         end else if (w_v_i && (w_idx_i == idx_width_lp'(k))) begin
            board_r[hi_lp-1:lo_lp] <= data_i[w_lp-1:0];
         end
      end
   end

   assign board_o = board_r;

endmodule

// File: rtl/bsg_cgol_input_deser.sv
// ---------------------------------------------------------------------------
// bsg_cgol_input_deser
// Collects a game request (one header word followed by the board body words)
// from a narrow ready/valid stream and presents the assembled board plus the
// frame count on a single ready/valid handshake.
// Ports:
//   clk_i, reset_i - clock, synchronous active-high reset
//   data_i, v_i    - upstream word and its valid
//   ready_o        - a word can be accepted (high unless a request is held)
//   board_o        - assembled board, cell (r,c) at bit r*board_width_p+c
//   frames_o       - frame count from the header
//   v_o, ready_i   - downstream request valid / accept
// Configuration:
//   BSG_CGOL_DESER_CLAMP_EN - when defined, header frame counts above
//   max_game_length_p are saturated to max_game_length_p.
// ---------------------------------------------------------------------------
module bsg_cgol_input_deser
   import bsg_cgol_pkg::*;
#(
   parameter int board_width_p     = 32,
   parameter int max_game_length_p = 1024,
   parameter int data_width_p      = 64,
   localparam int game_len_width_lp = safe_clog2(max_game_length_p + 1),
   localparam int board_bits_lp     = board_width_p * board_width_p,
   localparam int body_words_lp     = (board_bits_lp + data_width_p - 1) / data_width_p,
   localparam int cnt_width_lp      = safe_clog2(body_words_lp)
) (
   input  logic                         clk_i,
   input  logic                         reset_i,
   input  logic [data_width_p-1:0]      data_i,
   input  logic                         v_i,
   output logic                         ready_o,
   output logic [board_bits_lp-1:0]     board_o,
   output logic [game_len_width_lp-1:0] frames_o,
   output logic                         v_o,
   input  logic                         ready_i
);

   deser_state_e                 state_r;
   logic [cnt_width_lp-1:0]      cnt_r;
   logic [game_len_width_lp-1:0] frames_r;
   logic [game_len_width_lp-1:0] hdr_raw;
   logic [game_len_width_lp-1:0] hdr_frames;
   logic                         accept;
   logic                         last_word;

   // Handshake outputs depend on the registered state only, so there is no
   // combinational path from ready_i or v_i to either of them.
   assign ready_o = (state_r != e_full);
   assign v_o     = (state_r == e_full);
   assign accept  = v_i & ready_o;

   assign last_word = (cnt_r == cnt_width_lp'(body_words_lp - 1));

   // Frame count from the header word, optionally saturated before it is
   // registered.
   assign hdr_raw = data_i[hdr_frames_lsb_gp +: game_len_width_lp];
`ifdef BSG_CGOL_DESER_CLAMP_EN
   assign hdr_frames = (hdr_raw > game_len_width_lp'(max_game_length_p))
                       ? game_len_width_lp'(max_game_length_p) : hdr_raw;
`else
   assign hdr_frames = hdr_raw;
`endif

   // Request sequencer: header word, then body words counted by cnt_r, then
   // hold the full request until downstream takes it. The counter stops at
   // the last index instead of wrapping; the next header clears it.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_r  <= e_header;
         cnt_r    <= '0;
         frames_r <= '0;
      end else begin
         case (state_r)
            e_header: begin
               if (accept) begin
                  frames_r <= hdr_frames;
                  cnt_r    <= '0;
                  state_r  <= e_body;
               end
            end
            e_body: begin
               if (accept) begin
                  if (last_word) begin
                     state_r <= e_full;
                  end else begin
                     cnt_r <= cnt_r + cnt_width_lp'(1);
                  end
               end
            end
            e_full: begin
               if (ready_i) begin
                  state_r <= e_header;
               end
            end
            default: begin
               state_r <= e_header;
            end
         endcase
      end
   end

   assign frames_o = frames_r;

   bsg_cgol_word_assembler #(
      .data_width_p  (data_width_p),
      .board_bits_lp (board_bits_lp)
   ) assembler (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .w_v_i   (accept && (state_r == e_body)),
      .w_idx_i (cnt_r),
      .data_i  (data_i),
      .board_o (board_o)
   );

endmodule

// File: tb/tb_bsg_cgol_input_deser.sv
// ---------------------------------------------------------------------------
// tb_bsg_cgol_input_deser
// Directed bench for bsg_cgol_input_deser with a 4x4 board, 8-bit words and
// a maximum game length of 10 (4-bit frame count, 2 body words).
// ---------------------------------------------------------------------------
module tb_bsg_cgol_input_deser;

   logic        clk_i;
   logic        reset_i;
   logic [7:0]  data_i;
   logic        v_i;
   logic        ready_o;
   logic [15:0] board_o;
   logic [3:0]  frames_o;
   logic        v_o;
   logic        ready_i;

   int checks;
   int fails;

   bsg_cgol_input_deser #(
      .board_width_p     (4),
      .max_game_length_p (10),
      .data_width_p      (8)
   ) dut (
      .clk_i    (clk_i),
      .reset_i  (reset_i),
      .data_i   (data_i),
      .v_i      (v_i),
      .ready_o  (ready_o),
      .board_o  (board_o),
      .frames_o (frames_o),
      .v_o      (v_o),
      .ready_i  (ready_i)
   );

   // Free-running clock, 10 time-unit period.
   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end

   // Advance one clock and settle 1 unit past the edge, where inputs are
   // changed and outputs are sampled.
   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   // Present one word (or an idle cycle) for exactly one clock.
   task automatic applyStimulus(input logic v, input logic [7:0] d);
      v_i    = v;
      data_i = d;
      tick();
      v_i    = 1'b0;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         fails++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic checkIdle(input string tag);
      checkOutput({tag, "_ready"}, 32'(ready_o), 32'd1);
      checkOutput({tag, "_v"},     32'(v_o),     32'd0);
   endtask

   task automatic checkFull(input string tag, input logic [15:0] b, input logic [3:0] f);
      checkOutput({tag, "_v"},      32'(v_o),      32'd1);
      checkOutput({tag, "_ready"},  32'(ready_o),  32'd0);
      checkOutput({tag, "_board"},  32'(board_o),  32'(b));
      checkOutput({tag, "_frames"}, 32'(frames_o), 32'(f));
   endtask

   logic [7:0]  stream [6];
   logic [15:0] cap_board [4];
   logic [3:0]  cap_frames [4];
   int          idx, cyc, bubbles, xfers;
   logic        accepted;
   logic [3:0]  clamp_exp;

   initial begin
      checks  = 0;
      fails   = 0;
      reset_i = 1'b1;
      v_i     = 1'b0;
      data_i  = 8'h00;
      ready_i = 1'b1;
      tick();
      tick();
      reset_i = 1'b0;

      // Reset state
      checkIdle("reset");
      checkOutput("reset_board",  32'(board_o),  32'h0);
      checkOutput("reset_frames", 32'(frames_o), 32'h0);

      // Basic back-to-back request
      $display("[TB] basic request");
      applyStimulus(1'b1, 8'h05);
      checkIdle("basic_hdr");
      applyStimulus(1'b1, 8'hA5);
      checkIdle("basic_b0");
      applyStimulus(1'b1, 8'h3C);
      checkFull("basic", 16'h3CA5, 4'd5);
      tick();
      checkIdle("basic_after");

      // Upstream gaps of 3 idle cycles between words
      $display("[TB] upstream gaps");
      applyStimulus(1'b1, 8'h05);
      for (int g = 0; g < 3; g++) begin
         applyStimulus(1'b0, 8'hFF);
         checkIdle("gap_hdr");
         checkOutput("gap_hdr_frames", 32'(frames_o), 32'd5);
      end
      applyStimulus(1'b1, 8'hA5);
      for (int g = 0; g < 3; g++) begin
         applyStimulus(1'b0, 8'hFF);
         checkIdle("gap_b0");
      end
      applyStimulus(1'b1, 8'h3C);
      checkFull("gap", 16'h3CA5, 4'd5);
      tick();
      checkIdle("gap_after");

      // Backpressure: hold ready_i low with upstream still pushing
      $display("[TB] backpressure");
      ready_i = 1'b0;
      applyStimulus(1'b1, 8'h07);
      applyStimulus(1'b1, 8'h12);
      applyStimulus(1'b1, 8'h34);
      for (int c = 0; c < 5; c++) begin
         applyStimulus(1'b1, 8'hEE);
         checkFull("bp_hold", 16'h3412, 4'd7);
      end
      ready_i = 1'b1;
      applyStimulus(1'b1, 8'hEE);
      checkIdle("bp_xfer");
      checkOutput("bp_xfer_frames", 32'(frames_o), 32'd7);
      tick();
      checkIdle("bp_single");

      // Clamp behaviour depends on build configuration
      $display("[TB] clamp");
`ifdef BSG_CGOL_DESER_CLAMP_EN
      clamp_exp = 4'd10;
`else
      clamp_exp = 4'd14;
`endif
      applyStimulus(1'b1, 8'h0E);
      applyStimulus(1'b1, 8'h00);
      applyStimulus(1'b1, 8'h00);
      checkFull("clamp_0e", 16'h0000, clamp_exp);
      tick();
      applyStimulus(1'b1, 8'hF5);
      applyStimulus(1'b1, 8'h01);
      applyStimulus(1'b1, 8'h80);
      checkFull("clamp_f5", 16'h8001, 4'd5);
      tick();

      // Reset in the middle of a request
      $display("[TB] reset mid-request");
      applyStimulus(1'b1, 8'h03);
      applyStimulus(1'b1, 8'hFF);
      checkOutput("mid_partial_board", 32'(board_o), 32'h80FF);
      reset_i = 1'b1;
      tick();
      reset_i = 1'b0;
      checkIdle("mid_reset");
      checkOutput("mid_reset_board",  32'(board_o),  32'h0);
      checkOutput("mid_reset_frames", 32'(frames_o), 32'h0);
      applyStimulus(1'b1, 8'h02);
      applyStimulus(1'b1, 8'h11);
      applyStimulus(1'b1, 8'h22);
      checkFull("mid_new", 16'h2211, 4'd2);
      tick();

      // Two requests streamed continuously; a word is held until accepted
      $display("[TB] back-to-back");
      stream[0] = 8'h09; stream[1] = 8'hAB; stream[2] = 8'hCD;
      stream[3] = 8'h04; stream[4] = 8'h56; stream[5] = 8'h78;
      idx = 0; cyc = 0; bubbles = 0; xfers = 0;
      while (idx < 6 && cyc < 40) begin
         v_i      = 1'b1;
         data_i   = stream[idx];
         accepted = ready_o;
         if (v_o && ready_i && xfers < 4) begin
            cap_board[xfers]  = board_o;
            cap_frames[xfers] = frames_o;
            xfers++;
         end
         tick();
         cyc++;
         if (accepted) idx++;
         else bubbles++;
      end
      v_i = 1'b0;
      checkOutput("b2b_all_accepted", 32'(idx), 32'd6);
      checkOutput("b2b_bubbles",      32'(bubbles), 32'd1);
      checkOutput("b2b_xfers_mid",    32'(xfers), 32'd1);
      checkOutput("b2b_first_board",  32'(cap_board[0]),  32'hCDAB);
      checkOutput("b2b_first_frames", 32'(cap_frames[0]), 32'd9);
      checkFull("b2b_second", 16'h7856, 4'd4);
      tick();
      checkIdle("b2b_done");

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
